mdr_mem_handshake: RTL and testbench

//  Parametrised memory data register (MDR) sitting between the datapath bus and memory.

---
 rtl/mdr_mem_handshake.sv | 141 ++++++++++++++
 tb/tb_mdr_mem_handshake.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_mem_handshake.sv
// Memory data register with legacy single-cycle load/drive plus a req/ack memory handshake.
// Optional wait-cycle timeout with sticky err is enabled by defining MDR_TIMEOUT_EN.
module mdr_mem_handshake #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned           TIMEOUT_CYC = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MDRin,
  input  logic                  MDRout,
  input  logic                  Read,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  output logic [DATA_WIDTH-1:0] BusMuxIn,
  input  logic [DATA_WIDTH-1:0] Mdata,
  input  logic                  rd_start,
  input  logic                  wr_start,
  input  logic [1:0]            size,
  input  logic                  uns,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic                  done_q, done_d;
  logic                  timeout_hit;
  logic                  start_ok;

  // Sub-word load: size 01 = half, 10 = byte, otherwise full word.
  function automatic logic [DATA_WIDTH-1:0] ext(input logic [DATA_WIDTH-1:0] x,
                                                input logic [1:0]            sz,
                                                input logic                  u);
    logic [DATA_WIDTH-1:0] r;
    r = x;
    case (sz)
      2'b01:   r = {{(DATA_WIDTH-16){~u & x[15]}}, x[15:0]};
      2'b10:   r = {{(DATA_WIDTH-8){~u & x[7]}}, x[7:0]};
      default: r = x;
    endcase
    return r;
  endfunction

  // A start arriving while the completion pulse is still high is dropped.
  assign start_ok = ~done_q;

  always_comb begin
    state_d = state_q;
    mdr_d   = mdr_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok && wr_start) begin
          state_d = StWrWait;
        end else if (start_ok && rd_start) begin
          state_d = StRdWait;
        end else if (MDRin) begin
          mdr_d = Read ? ext(Mdata, size, uns) : BusMuxOut;
        end
      end
      StRdWait: begin
        if (mem_ack) begin
          mdr_d   = ext(Mdata, size, uns);
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      StWrWait: begin
        if (mem_ack) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mdr_q   <= RESET_VALUE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      done_q  <= done_d;
    end
  end

`ifdef MDR_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       waiting;

  assign waiting     = (state_q != StIdle);
  // Fires on the TIMEOUT_CYC-th wait cycle; an ack in that same cycle still wins.
  assign timeout_hit = waiting && (cnt_q == TimeoutLast);

  always_comb begin
    cnt_d = waiting ? cnt_q + 8'd1 : 8'd0;
    err_d = err_q | (timeout_hit & ~mem_ack);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Request lines come straight from state so reset removes them asynchronously.
  assign mem_req   = (state_q != StIdle);
  assign mem_we    = (state_q == StWrWait);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign mem_wdata = mdr_q;
  assign BusMuxIn  = MDRout ? mdr_q : '0;

endmodule

// File: tb/tb_mdr_mem_handshake.sv
// Scoreboard bench for mdr_mem_handshake: expected MDR values are queued at stimulus time.
module tb_mdr_mem_handshake;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          MDRin, MDRout, Read;
  logic [DW-1:0] BusMuxOut, BusMuxIn, Mdata, mem_wdata;
  logic          rd_start, wr_start, uns, mem_req, mem_we, mem_ack, busy, done, err;
  logic [1:0]    size;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdr_model;
  int            n_checks = 0;
  int            n_fail   = 0;

  mdr_mem_handshake #(
    .DATA_WIDTH (DW),
    .RESET_VALUE('0),
    .TIMEOUT_CYC(15)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MDRin    (MDRin),
    .MDRout   (MDRout),
    .Read     (Read),
    .BusMuxOut(BusMuxOut),
    .BusMuxIn (BusMuxIn),
    .Mdata    (Mdata),
    .rd_start (rd_start),
    .wr_start (wr_start),
    .size     (size),
    .uns      (uns),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_ext(input logic [DW-1:0] d, input logic [1:0] sz,
                                              input logic u);
    if (sz == 2'b01) return u ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
    if (sz == 2'b10) return u ? {24'h0, d[7:0]} : {{24{d[7]}}, d[7:0]};
    return d;
  endfunction

  task automatic pop_check(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // Raise ack for one cycle, then wait (bounded) for the done pulse.
  task automatic ack_and_wait(input string tag, output bit found);
    found   = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check({tag, "_done_seen"}, 32'd0, 32'd1);
  endtask

  task automatic bus_load(input logic [DW-1:0] v);
    @(negedge clk);
    MDRin = 1'b1; Read = 1'b0; BusMuxOut = v;
    @(negedge clk);
    MDRin = 1'b0;
    mdr_model = v;
  endtask

  task automatic do_read(input string tag, input logic [DW-1:0] d, input logic [1:0] sz,
                         input logic u, input int waits);
    bit found;
    @(negedge clk);
    rd_start = 1'b1; size = sz; uns = u; Mdata = d;
    exp_q.push_back(model_ext(d, sz, u));
    @(negedge clk);
    rd_start = 1'b0;
    check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    repeat (waits - 1) @(negedge clk);
    check({tag, "_busy_wait"}, {31'd0, busy}, 32'd1);
    ack_and_wait(tag, found);
    if (found) begin
      pop_check({tag, "_mdr"}, BusMuxIn);
      mdr_model = model_ext(d, sz, u);
      check({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
      rd_start = 1'b1;  // ignored: coincides with done
      @(negedge clk);
      rd_start = 1'b0;
      check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
      check({tag, "_b2b_ignored"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    bit found;
    reset = 1'b0; MDRin = 1'b0; MDRout = 1'b1; Read = 1'b0; BusMuxOut = '0; Mdata = '0;
    rd_start = 1'b0; wr_start = 1'b0; size = 2'b00; uns = 1'b0; mem_ack = 1'b0;
    mdr_model = '0;
    #12;
    check("rst_mdr", BusMuxIn, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Legacy load from memory data, then MDRin low must hold the value.
    @(negedge clk);
    Mdata = 32'd23; Read = 1'b1; MDRin = 1'b1;
    exp_q.push_back(32'd23);
    @(negedge clk);
    MDRin = 1'b0; Mdata = 32'd35;
    @(negedge clk);
    pop_check("legacy_load", BusMuxIn);

    // Bus load and drive gating.
    exp_q.push_back(32'hDEADBEEF);
    bus_load(32'hDEADBEEF);
    pop_check("bus_load", BusMuxIn);
    MDRout = 1'b0;
    #1 check("mdrout_gate", BusMuxIn, 32'd0);
    MDRout = 1'b1;

    // Handshaked sub-word reads.
    do_read("rd_byte_s", 32'h00000080, 2'b10, 1'b0, 3);
    do_read("rd_byte_u", 32'h00000080, 2'b10, 1'b1, 3);
    do_read("rd_half_s", 32'h1234ABCD, 2'b01, 1'b0, 1);
    do_read("rd_word11", 32'hA5A5F00F, 2'b11, 1'b1, 2);

    // Write handshake with ignored starts/loads mid-wait.
    bus_load(32'h12345678);
    @(negedge clk);
    wr_start = 1'b1;
    exp_q.push_back(32'h12345678);
    @(negedge clk);
    wr_start = 1'b0;
    check("wr_req", {31'd0, mem_req}, 32'd1);
    check("wr_we", {31'd0, mem_we}, 32'd1);
    check("wr_wdata", mem_wdata, 32'h12345678);
    rd_start = 1'b1; MDRin = 1'b1; Read = 1'b0; BusMuxOut = 32'hCAFEF00D;
    @(negedge clk);
    rd_start = 1'b0; MDRin = 1'b0;
    check("wr_ignore_mdrin", mem_wdata, 32'h12345678);
    check("wr_still_we", {31'd0, mem_we}, 32'd1);
    ack_and_wait("wr", found);
    if (found) begin
      check("wr_req_drop", {31'd0, mem_req}, 32'd0);
      check("wr_we_drop", {31'd0, mem_we}, 32'd0);
      pop_check("wr_mdr_kept", BusMuxIn);
      @(negedge clk);
      check("wr_no_restart", {31'd0, busy}, 32'd0);
    end

    // Ack while idle has no effect.
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack_busy", {31'd0, busy}, 32'd0);
    check("idle_ack_done", {31'd0, done}, 32'd0);

    // Asynchronous reset in the middle of a read.
    @(negedge clk);
    rd_start = 1'b1; Mdata = 32'h77; size = 2'b00;
    @(negedge clk);
    rd_start = 1'b0;
    check("rstmid_req_before", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rstmid_req", {31'd0, mem_req}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_mdr", BusMuxIn, 32'd0);
    check("rstmid_done", {31'd0, done}, 32'd0);
    mdr_model = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_after_done", {31'd0, done}, 32'd0);

`ifdef MDR_TIMEOUT_EN
    begin
      int cyc;
      bit saw_done;
      bus_load(32'h0BADF00D);
      @(negedge clk);
      rd_start = 1'b1; Mdata = 32'h55;
      @(negedge clk);
      rd_start = 1'b0;
      cyc = 1; saw_done = 1'b0;
      while (busy && cyc < 40) begin
        @(negedge clk);
        if (done) saw_done = 1'b1;
        if (busy) cyc++;
      end
      check("to_wait_cycles", cyc, 32'd15);
      check("to_err", {31'd0, err}, 32'd1);
      check("to_busy", {31'd0, busy}, 32'd0);
      check("to_no_done", {31'd0, saw_done}, 32'd0);
      check("to_mdr_kept", BusMuxIn, mdr_model);
      do_read("to_rd_after", 32'h000000F1, 2'b00, 1'b0, 2);
      check("to_err_sticky", {31'd0, err}, 32'd1);
    end
`else
    check("no_timeout_err", {31'd0, err}, 32'd0);
`endif

    check("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
